tg_sync_out: RTL and testbench

Display-side output stage for the test-pattern timing generator. Consumes the free-running H/V/F counters and the registered R/G/B pattern bytes. Produces active-high HSYNC, VSYNC, DE, field flag and blank-gated RGB, all aligned on one output register. A continuity monitor tracks the counters; it blanks DE after any discontinuity (for example an XVRST restart) until the next frame origin, and counts such events.

---
 rtl/tg_pkg.sv | 37 +++
 rtl/tg_cont_mon.sv | 92 +++++++++
 rtl/tg_sync_out.sv | 138 +++++++++++++
 tb/tg_sync_out_tb_placeholder_removed.sv | 1 +
 tb/tb_tg_sync_out.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tg_pkg.sv
// ---------------------------------------------------------------------------
// tg_pkg
// Shared definitions for the test-pattern timing generator and its output
// stage: default raster timing, monitor state encoding and a window-decode
// helper used by every block that turns counters into sync/active flags.
// ---------------------------------------------------------------------------
package tg_pkg;

    // Default raster: 910 pixels x 262 lines per field.
    localparam int unsigned TG_H_TOTAL     = 910;
    localparam int unsigned TG_V_TOTAL     = 262;
    localparam int unsigned TG_H_ACT_START = 128;
    localparam int unsigned TG_H_ACT_LEN   = 720;
    localparam int unsigned TG_HS_START    = 0;
    localparam int unsigned TG_HS_LEN      = 67;
    localparam int unsigned TG_V_ACT_START = 21;
    localparam int unsigned TG_V_ACT_LEN   = 240;
    localparam int unsigned TG_VS_START    = 3;
    localparam int unsigned TG_VS_LEN      = 3;

    // Continuity monitor states.
    typedef enum logic {
        MON_SEARCH = 1'b0,
        MON_RUN    = 1'b1
    } mon_state_t;

    // Start-inclusive, end-exclusive window test. The position is widened
    // to 32 bits so start+len can never wrap for any 16-bit counter value.
    function automatic logic in_window(input logic [15:0] pos,
                                       input int unsigned start,
                                       input int unsigned len);
        logic [31:0] p;
        p = {16'b0, pos};
        return (p >= start) && (p < (start + len));
    endfunction

endpackage

// File: rtl/tg_cont_mon.sv
// ---------------------------------------------------------------------------
// tg_cont_mon
// Continuity monitor for the free-running H/V counters. It predicts the next
// (H,V) from the previous one and drops out of RUN on any discontinuity,
// counting each such event. RUN is only (re)entered on an observed frame
// origin (H=0, V=0) while searching.
//
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   en         - clock enable; all state holds while low
//   h, v       - pixel and line counters
//   lock       - high while the monitor is in RUN
//   err_count  - saturating count of discontinuities seen in RUN
// ---------------------------------------------------------------------------
module tg_cont_mon
    import tg_pkg::*;
#(
    parameter int unsigned H_TOTAL = TG_H_TOTAL,
    parameter int unsigned V_TOTAL = TG_V_TOTAL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] h,
    input  logic [15:0] v,
    output logic        lock,
    output logic [7:0]  err_count
);

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

    mon_state_t  state;
    logic [15:0] prev_h;
    logic [15:0] prev_v;
    logic [7:0]  err_cnt;

    logic        h_wrap;
    logic [15:0] exp_h;
    logic [15:0] exp_v;
    logic        origin;
    logic        mismatch;

    // Expected next position. An out-of-range current value can never equal
    // this prediction, so it is caught as a discontinuity without a separate
    // range check.
    always_comb begin
        h_wrap = (prev_h == H_LAST);
        exp_h  = h_wrap ? 16'd0 : prev_h + 16'd1;
        exp_v  = prev_v;
        if (h_wrap) begin
            exp_v = (prev_v == V_LAST) ? 16'd0 : prev_v + 16'd1;
        end
        origin   = (h == 16'd0) && (v == 16'd0);
        mismatch = (h != exp_h) || (v != exp_v);
    end

    // A mismatch that lands on an origin still sends us to SEARCH; relock
    // waits for the next origin so a restart is never accepted blindly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MON_SEARCH;
            prev_h  <= '0;
            prev_v  <= '0;
            err_cnt <= '0;
        end else if (en) begin
            prev_h <= h;
            prev_v <= v;
            case (state)
                MON_SEARCH: begin
                    if (origin) begin
                        state <= MON_RUN;
                    end
                end
                MON_RUN: begin
                    if (mismatch) begin
                        state <= MON_SEARCH;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: state <= MON_SEARCH;
            endcase
        end
    end

    assign lock      = (state == MON_RUN);
    assign err_count = err_cnt;

endmodule

// File: rtl/tg_sync_out.sv
// ---------------------------------------------------------------------------
// tg_sync_out
// Display-side output stage of the test-pattern timing generator. Decodes
// sync and active windows from the H/V/F counters, aligns them with the
// pattern bytes (which arrive one enabled cycle later) and presents
// HSYNC/VSYNC/DE/FIELD/RGB from a single output register. DE and RGB are
// blanked while the continuity monitor is not locked; syncs always run.
//
// Ports:
//   CK_i          - clock
//   XAR_i         - asynchronous active-low reset
//   CK_EE_i       - clock enable
//   HCTRs_i       - pixel counter
//   VCTRs_i       - line counter
//   FCTRs_i       - field counter (bit 0 becomes FIELD_o)
//   QQs_[RGB]_i   - pattern bytes, one enabled cycle behind the counters
//   QQs_[RGB]_o   - blank-gated pixel data
//   HS_o, VS_o    - active-high syncs
//   DE_o          - data enable, gated by lock
//   FIELD_o       - field flag
//   LOCK_o        - continuity monitor in RUN
//   ERRCTRs_o     - saturating discontinuity count
// ---------------------------------------------------------------------------
module tg_sync_out
    import tg_pkg::*;
#(
    parameter int unsigned H_TOTAL     = TG_H_TOTAL,
    parameter int unsigned V_TOTAL     = TG_V_TOTAL,
    parameter int unsigned H_ACT_START = TG_H_ACT_START,
    parameter int unsigned H_ACT_LEN   = TG_H_ACT_LEN,
    parameter int unsigned HS_START    = TG_HS_START,
    parameter int unsigned HS_LEN      = TG_HS_LEN,
    parameter int unsigned V_ACT_START = TG_V_ACT_START,
    parameter int unsigned V_ACT_LEN   = TG_V_ACT_LEN,
    parameter int unsigned VS_START    = TG_VS_START,
    parameter int unsigned VS_LEN      = TG_VS_LEN
) (
    input  logic        CK_i,
    input  logic        XAR_i,
    input  logic        CK_EE_i,
    input  logic [15:0] HCTRs_i,
    input  logic [15:0] VCTRs_i,
    input  logic [7:0]  FCTRs_i,
    input  logic [7:0]  QQs_R_i,
    input  logic [7:0]  QQs_G_i,
    input  logic [7:0]  QQs_B_i,
    output logic [7:0]  QQs_R_o,
    output logic [7:0]  QQs_G_o,
    output logic [7:0]  QQs_B_o,
    output logic        HS_o,
    output logic        VS_o,
    output logic        DE_o,
    output logic        FIELD_o,
    output logic        LOCK_o,
    output logic [7:0]  ERRCTRs_o
);

    logic h_act;
    logic v_act;
    logic hs_dec;
    logic vs_dec;

    logic de_s1;
    logic hs_s1;
    logic vs_s1;
    logic field_s1;

    logic lock;
    logic de_qual;
    logic field_unused;

    // Only the field parity is needed downstream.
    assign field_unused = ^FCTRs_i[7:1];

    always_comb begin
        h_act  = in_window(HCTRs_i, H_ACT_START, H_ACT_LEN);
        v_act  = in_window(VCTRs_i, V_ACT_START, V_ACT_LEN);
        hs_dec = in_window(HCTRs_i, HS_START, HS_LEN);
        vs_dec = in_window(VCTRs_i, VS_START, VS_LEN);
    end

    tg_cont_mon #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cont_mon (
        .clk       (CK_i),
        .rst_n     (XAR_i),
        .en        (CK_EE_i),
        .h         (HCTRs_i),
        .v         (VCTRs_i),
        .lock      (lock),
        .err_count (ERRCTRs_o)
    );

    // Stage 1: decoded flags, one cycle after the counters, so they line
    // up with the pattern bytes derived from the same counters.
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            de_s1    <= 1'b0;
            hs_s1    <= 1'b0;
            vs_s1    <= 1'b0;
            field_s1 <= 1'b0;
        end else if (CK_EE_i) begin
            de_s1    <= h_act & v_act;
            hs_s1    <= hs_dec;
            vs_s1    <= vs_dec;
            field_s1 <= FCTRs_i[0];
        end
    end

    // Lock as it stands at this update; a relock taken on an origin is
    // already visible here when that origin's pixel reaches stage 2.
    assign de_qual = de_s1 & lock;

    // Stage 2: the single output register.
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            QQs_R_o <= '0;
            QQs_G_o <= '0;
            QQs_B_o <= '0;
            HS_o    <= 1'b0;
            VS_o    <= 1'b0;
            DE_o    <= 1'b0;
            FIELD_o <= 1'b0;
        end else if (CK_EE_i) begin
            QQs_R_o <= de_qual ? QQs_R_i : 8'd0;
            QQs_G_o <= de_qual ? QQs_G_i : 8'd0;
            QQs_B_o <= de_qual ? QQs_B_i : 8'd0;
            HS_o    <= hs_s1;
            VS_o    <= vs_s1;
            DE_o    <= de_qual;
            FIELD_o <= field_s1;
        end
    end

    assign LOCK_o = lock;

endmodule

// File: tb/tg_sync_out_tb_placeholder_removed.sv


// File: tb/tb_tg_sync_out.sv
// ---------------------------------------------------------------------------
// tb_tg_sync_out
// Randomized scoreboard bench for tg_sync_out on a reduced raster. The
// reference model tracks the raster as a linear pixel index and derives
// each expected output from the counters of the previous enabled step.
// ---------------------------------------------------------------------------
module tb_tg_sync_out;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HAS = 8;
    localparam int HAL = 24;
    localparam int HSS = 0;
    localparam int HSL = 4;
    localparam int VAS = 3;
    localparam int VAL = 12;
    localparam int VSS = 1;
    localparam int VSL = 2;

    logic        CK_i    = 1'b0;
    logic        XAR_i   = 1'b1;
    logic        CK_EE_i = 1'b0;
    logic [15:0] HCTRs_i = '0;
    logic [15:0] VCTRs_i = '0;
    logic [7:0]  FCTRs_i = '0;
    logic [7:0]  QQs_R_i = '0;
    logic [7:0]  QQs_G_i = '0;
    logic [7:0]  QQs_B_i = '0;
    logic [7:0]  QQs_R_o;
    logic [7:0]  QQs_G_o;
    logic [7:0]  QQs_B_o;
    logic        HS_o;
    logic        VS_o;
    logic        DE_o;
    logic        FIELD_o;
    logic        LOCK_o;
    logic [7:0]  ERRCTRs_o;

    tg_sync_out #(
        .H_TOTAL(HT), .V_TOTAL(VT),
        .H_ACT_START(HAS), .H_ACT_LEN(HAL),
        .HS_START(HSS), .HS_LEN(HSL),
        .V_ACT_START(VAS), .V_ACT_LEN(VAL),
        .VS_START(VSS), .VS_LEN(VSL)
    ) dut (
        .CK_i(CK_i), .XAR_i(XAR_i), .CK_EE_i(CK_EE_i),
        .HCTRs_i(HCTRs_i), .VCTRs_i(VCTRs_i), .FCTRs_i(FCTRs_i),
        .QQs_R_i(QQs_R_i), .QQs_G_i(QQs_G_i), .QQs_B_i(QQs_B_i),
        .QQs_R_o(QQs_R_o), .QQs_G_o(QQs_G_o), .QQs_B_o(QQs_B_o),
        .HS_o(HS_o), .VS_o(VS_o), .DE_o(DE_o), .FIELD_o(FIELD_o),
        .LOCK_o(LOCK_o), .ERRCTRs_o(ERRCTRs_o)
    );

    always #5 CK_i = ~CK_i;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        field;
        logic        lock;
        logic [7:0]  err;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp = '0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    bit m_locked;
    int m_err;
    bit m_have;
    int m_ph, m_pv, m_pf;
    int m_prev_idx;

    // Counter generator state
    int gh, gv, gf;

    function automatic bit inWin(int x, int s, int l);
        return (x >= s) && (x < s + l);
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll(string tag, exp_t e);
        checkOutput({tag, "_hs"}, 32'(HS_o), 32'(e.hs));
        checkOutput({tag, "_vs"}, 32'(VS_o), 32'(e.vs));
        checkOutput({tag, "_de"}, 32'(DE_o), 32'(e.de));
        checkOutput({tag, "_field"}, 32'(FIELD_o), 32'(e.field));
        checkOutput({tag, "_lock"}, 32'(LOCK_o), 32'(e.lock));
        checkOutput({tag, "_err"}, 32'(ERRCTRs_o), 32'(e.err));
        checkOutput({tag, "_rgb"}, 32'({QQs_R_o, QQs_G_o, QQs_B_o}), 32'(e.rgb));
    endtask

    task automatic modelReset();
        m_locked   = 0;
        m_err      = 0;
        m_have     = 0;
        m_ph       = 0;
        m_pv       = 0;
        m_pf       = 0;
        m_prev_idx = 0;
    endtask

    // Drive one cycle of inputs at the falling edge. On enabled cycles the
    // model advances and the expected outputs after the next rising edge
    // are queued; disabled cycles drive junk counters that must be ignored.
    task automatic applyStimulus(int h, int v, int f, bit en);
        exp_t        e;
        logic [23:0] rgb;
        bit          cont;
        @(negedge CK_i);
        rgb = 24'($urandom);
        {QQs_R_i, QQs_G_i, QQs_B_i} = rgb;
        CK_EE_i = en;
        if (en) begin
            HCTRs_i = 16'(h);
            VCTRs_i = 16'(v);
            FCTRs_i = 8'(f);
            e = '0;
            if (m_have) begin
                e.hs    = inWin(m_ph, HSS, HSL);
                e.vs    = inWin(m_pv, VSS, VSL);
                e.field = m_pf[0];
                e.de    = inWin(m_ph, HAS, HAL) && inWin(m_pv, VAS, VAL) && m_locked;
            end
            e.rgb = e.de ? rgb : 24'd0;
            if (!m_locked) begin
                m_locked = (h == 0) && (v == 0);
            end else begin
                cont = (h < HT) && (v < VT) &&
                       ((v * HT + h) == ((m_prev_idx + 1) % (HT * VT)));
                if (!cont) begin
                    m_locked = 0;
                    if (m_err < 255) m_err++;
                end
            end
            m_prev_idx = v * HT + h;
            e.lock = m_locked;
            e.err  = 8'(m_err);
            m_ph   = h;
            m_pv   = v;
            m_pf   = f;
            m_have = 1;
            sb.push_back(e);
        end else begin
            HCTRs_i = 16'($urandom);
            VCTRs_i = 16'($urandom);
            FCTRs_i = 8'($urandom);
        end
    endtask

    task automatic genStep(bit en);
        applyStimulus(gh, gv, gf, en);
        if (en) begin
            if (gh >= HT - 1) begin
                gh = 0;
                if (gv >= VT - 1) begin
                    gv = 0;
                    gf = (gf + 1) & 255;
                end else begin
                    gv++;
                end
            end else begin
                gh++;
            end
        end
    endtask

    task automatic runTo(int h, int v);
        int budget;
        budget = 2 * HT * VT;
        while (!(gh == h && gv == v) && budget > 0) begin
            genStep(1);
            budget--;
        end
        if (budget == 0) checkOutput("runto_timeout", 0, 1);
    endtask

    // Monitor: after every rising edge, pop and compare on enabled cycles,
    // otherwise the outputs must be frozen at the last expected value.
    initial begin
        bit en_s, rst_s;
        forever begin
            @(posedge CK_i);
            en_s  = CK_EE_i;
            rst_s = XAR_i;
            #1;
            if (!rst_s || !XAR_i) begin
                last_exp = '0;
            end else if (en_s) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_empty", 0, 1);
                end else begin
                    last_exp = sb.pop_front();
                    compareAll("out", last_exp);
                end
            end else begin
                compareAll("hold", last_exp);
            end
        end
    end

    initial begin
        modelReset();
        gh = 0; gv = 0; gf = 0;

        #2 XAR_i = 1'b0;
        #1 compareAll("reset", '0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        XAR_i = 1'b1;

        // Clean raster from the origin, CK_EE tied high
        repeat (HT * VT + 300) genStep(1);

        // Restart mid-field to the origin
        runTo(20, 10);
        gh = 0; gv = 0;
        repeat (HT * VT + 100) genStep(1);

        // Single skipped pixel
        runTo(25, 5);
        gh = 27;
        repeat (HT * VT + 100) genStep(1);

        // Enable at 1-in-2, then random enable
        for (int i = 0; i < 1200; i++) genStep(i % 2 == 0);
        repeat (800) genStep($urandom_range(0, 2) != 0);

        // Drive the error counter into saturation
        repeat (310) begin
            applyStimulus(0, 0, 0, 1);
            applyStimulus(($urandom_range(0, 1) != 0) ? 1000 : 7, 3, 0, 1);
        end
        @(posedge CK_i);
        #2 checkOutput("err_saturated", 32'(ERRCTRs_o), 32'(m_err));

        // Random glitches on a running raster
        gh = 0; gv = 0;
        repeat (2000) begin
            if ($urandom_range(0, 99) == 0) begin
                gh = $urandom_range(0, HT + 5);
                gv = $urandom_range(0, VT - 1);
            end
            genStep($urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of a cycle
        @(posedge CK_i);
        #2 XAR_i = 1'b0;
        #1 compareAll("async_rst", '0);
        modelReset();
        repeat (2) applyStimulus(0, 0, 0, 0);
        XAR_i = 1'b1;
        repeat (HT * VT + 50) genStep(1);

        @(posedge CK_i);
        #2 checkOutput("sb_drain", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
